cc_frame_scheduler: RTL
=======================

# cc_frame_scheduler

Frame-level sequencer for the ColorChord pipeline. It counts audio-buffer reads from the DFT and, every `DECIM` reads, waits `DFT_SETTLE` cycles for the bins to settle before starting the NoteFinder. It then hands NoteFinder completion to the LinearVisualizer and gates the LED driver start. It never re-triggers a busy stage: a request that arrives while its stage is busy is dropped and counted.

## Interface
Parameters:
- `DECIM`, 64: number of `doingRead` pulses per NoteFinder cycle; must be ≥1.
- `DFT_SETTLE`, 4: cycles from the decimating `doingRead` to `nfStart`; must be ≥1.
- `CNT_W`, 16: width of the overrun and drop counters.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous reset, active-high.
- `enable`  in  1  when low, no new frames are triggered.
- `clearStats`  in  1  synchronous clear of both counters.
- `doingRead`  in  1  DFT sample-read strobe, 1 cycle wide.
- `nfFinished`  in  1  NoteFinder done pulse.
- `lvDataValid`  in  1  visualizer RGB/LEDCounts valid pulse.
- `ledDone`  in  1  LED driver frame-complete pulse.
- `nfStart`  out  1  NoteFinder `startCycle` pulse.
- `lvStart`  out  1  visualizer `start` pulse.
- `ledStart`  out  1  LED driver `start` pulse.
- `busy`  out  1  high when either FSM is not idle.
- `nfOverruns`  out  CNT_W  saturating count of dropped NoteFinder triggers.
- `ledDrops`  out  CNT_W  saturating count of dropped LED frames.

## Operation
**Decimation counter (`readCnt`, range 0..DECIM-1)**
- Increments on each `doingRead` while `enable` is high, and wraps to 0.
- A "trigger" is a `doingRead` pulse at `readCnt == DECIM-1` with `enable` high.
- While `enable` is low, `readCnt` holds its value.

**NoteFinder FSM (`NF_IDLE`, `NF_SETTLE`, `NF_RUN`)**
- `NF_IDLE` + trigger: load `settleCnt = DFT_SETTLE-1`, go to `NF_SETTLE`.
- `NF_SETTLE`: decrement `settleCnt`. At 0, register `nfStart`=1 and go to `NF_RUN`.
- `NF_RUN` + `nfFinished`: register `lvStart`=1 and go to `NF_IDLE`.
- A trigger in `NF_SETTLE`, or in `NF_RUN` without `nfFinished`: drop it and increment `nfOverruns`.
- A trigger in the same cycle as `nfFinished` in `NF_RUN`: pulse `lvStart`, accept the trigger, and go directly to `NF_SETTLE`. No overrun is counted.
- `nfFinished` in any state other than `NF_RUN`: ignored.

**LED FSM (`LED_IDLE`, `LED_BUSY`)**
- `LED_IDLE` + `lvDataValid`: register `ledStart`=1 and go to `LED_BUSY`.
- `LED_BUSY` + `ledDone` only: go to `LED_IDLE`.
- `LED_BUSY` + `lvDataValid` without `ledDone`: drop the frame and increment `ledDrops`.
- `LED_BUSY` + `ledDone` and `lvDataValid` in the same cycle: accept the frame, pulse `ledStart`, and stay in `LED_BUSY`.

**General rules**
- `enable` falling does not abort in-flight work. Both FSMs run to idle.
- Counters saturate at 2^CNT_W-1.
- `clearStats` wins over a simultaneous increment.
- Asynchronous reset, including mid-frame:
  - both FSMs return to idle;
  - `readCnt`, `settleCnt` and both counters go to 0;
  - all outputs go to 0.
  - No pulse is emitted on reset release.

## Timing
- All outputs are registered. Every pulse is exactly 1 cycle wide.
- Trigger `doingRead` high at cycle t → `nfStart` high at cycle t+DFT_SETTLE. With the default of 4, this equals the 4-stage delay line it replaces.
- `nfFinished` at cycle t → `lvStart` at t+1.
- `lvDataValid` at cycle t → `ledStart` at t+1.
- `busy` is combinational from state registers only, so it is high the cycle after entering a non-idle state.
- Counter updates are visible the cycle after the dropping event.

## Structure
- Add the enums `NFSchedState_t` and `LEDSchedState_t` to package `CCHW`.
- One sub-module, `SatCounter`, parameterised by width:
  - inputs `inc` and `clr`, output `count`;
  - asynchronous reset;
  - instantiated twice.
- Everything else lives in `cc_frame_scheduler`.

## Test plan
- **Decimation.** DECIM=4, DFT_SETTLE=4, 12 `doingRead` pulses 20 cycles apart, NoteFinder modelled finishing 10 cycles after start → exactly 3 `nfStart`, each 4 cycles after reads 4, 8 and 12; `nfOverruns`=0.
- **NoteFinder overrun.** DECIM=1, NoteFinder never finishes, 5 reads → 1 `nfStart`; `nfOverruns`=4. Then `clearStats` together with a 6th read → `nfOverruns`=0.
- **Simultaneous trigger and finish.** Trigger in the same cycle as `nfFinished` in `NF_RUN` → `lvStart` at t+1, `nfStart` at t+DFT_SETTLE, `nfOverruns` unchanged.
- **LED gating.** `lvDataValid` ×3 with no `ledDone` → 1 `ledStart`; `ledDrops`=2. Then `ledDone` and `lvDataValid` in the same cycle → `ledStart` at t+1, state stays `LED_BUSY`.
- **Reset mid-frame.** Assert `rst` during `NF_SETTLE` with `settleCnt`=2 → outputs 0 immediately, with no `nfStart` during or after reset. The next trigger needs a full DECIM reads.
- **Saturation and enable.** CNT_W=2, 6 LED drops → `ledDrops`=3. `enable` low during 10 reads → `readCnt` holds, no `nfStart`, and an in-flight `NF_RUN` still produces `lvStart`.

Source files
------------

// File: rtl/cc_frame_scheduler_pkg.sv
// Shared types for the ColorChord frame scheduler.
// Holds the NoteFinder and LED sequencing state enums and a width helper.
package CCHW;

  typedef enum logic [1:0] {
    NF_IDLE   = 2'd0,
    NF_SETTLE = 2'd1,
    NF_RUN    = 2'd2
  } NFSchedState_t;

  typedef enum logic {
    LED_IDLE = 1'b0,
    LED_BUSY = 1'b1
  } LEDSchedState_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cc_frame_scheduler_sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear takes priority over a same-cycle increment.
module SatCounter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cc_frame_scheduler.sv
// Frame sequencer: decimates DFT reads, delays the NoteFinder start while the
// bins settle, then chains NoteFinder -> LinearVisualizer -> LED driver.
//
// NoteFinder FSM
//   state     | meaning
//   NF_IDLE   | waiting for a decimation trigger
//   NF_SETTLE | counting down DFT settle time before nfStart
//   NF_RUN    | NoteFinder running, waiting for nfFinished
// LED FSM
//   state     | meaning
//   LED_IDLE  | LED driver free
//   LED_BUSY  | LED driver shifting a frame, waiting for ledDone
module cc_frame_scheduler
  import CCHW::*;
#(
  parameter int DECIM      = 64,
  parameter int DFT_SETTLE = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clearStats,
  input  logic             doingRead,
  input  logic             nfFinished,
  input  logic             lvDataValid,
  input  logic             ledDone,
  output logic             nfStart,
  output logic             lvStart,
  output logic             ledStart,
  output logic             busy,
  output logic [CNT_W-1:0] nfOverruns,
  output logic [CNT_W-1:0] ledDrops
);

  localparam int RC_W = min1_clog2(DECIM);
  localparam int ST_W = min1_clog2(DFT_SETTLE);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(DECIM - 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(DFT_SETTLE - 1);

  NFSchedState_t  nf_state, nf_state_d;
  LEDSchedState_t led_state, led_state_d;
  logic [RC_W-1:0] read_cnt;
  logic [ST_W-1:0] settle_cnt, settle_cnt_d;
  logic            trigger;
  logic            nf_accept;
  logic            nf_drop, led_drop;
  logic            nf_start_d, lv_start_d, led_start_d;

  assign trigger = doingRead && enable && (read_cnt == RC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_cnt <= '0;
    end else if (doingRead && enable) begin
      read_cnt <= (read_cnt == RC_LAST) ? '0 : read_cnt + RC_W'(1);
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nf_state   <= NF_IDLE;
      led_state  <= LED_IDLE;
      settle_cnt <= '0;
      nfStart    <= 1'b0;
      lvStart    <= 1'b0;
      ledStart   <= 1'b0;
    end else begin
      nf_state   <= nf_state_d;
      led_state  <= led_state_d;
      settle_cnt <= settle_cnt_d;
      nfStart    <= nf_start_d;
      lvStart    <= lv_start_d;
      ledStart   <= led_start_d;
    end
  end

  // nfStart is registered on the edge where settle_cnt reaches 0, so it lands
  // exactly DFT_SETTLE cycles after the trigger; a settle of 1 skips NF_SETTLE.
  always_comb begin
    nf_state_d   = nf_state;
    settle_cnt_d = settle_cnt;
    nf_accept    = 1'b0;
    case (nf_state)
      NF_IDLE: begin
        if (trigger) nf_accept = 1'b1;
      end
      NF_SETTLE: begin
        settle_cnt_d = settle_cnt - ST_W'(1);
        if (settle_cnt == ST_W'(1)) nf_state_d = NF_RUN;
      end
      NF_RUN: begin
        if (nfFinished && trigger) nf_accept = 1'b1;
        else if (nfFinished)       nf_state_d = NF_IDLE;
      end
      default: nf_state_d = NF_IDLE;
    endcase
    if (nf_accept) begin
      if (DFT_SETTLE == 1) begin
        nf_state_d = NF_RUN;
      end else begin
        nf_state_d   = NF_SETTLE;
        settle_cnt_d = ST_LOAD;
      end
    end

    led_state_d = led_state;
    case (led_state)
      LED_IDLE: if (lvDataValid) led_state_d = LED_BUSY;
      LED_BUSY: if (ledDone && !lvDataValid) led_state_d = LED_IDLE;
      default:  led_state_d = LED_IDLE;
    endcase
  end

  always_comb begin
    nf_start_d  = ((nf_state == NF_SETTLE) && (settle_cnt == ST_W'(1))) ||
                  (nf_accept && (DFT_SETTLE == 1));
    lv_start_d  = (nf_state == NF_RUN) && nfFinished;
    nf_drop     = trigger && !nf_accept;
    led_start_d = lvDataValid && ((led_state == LED_IDLE) || ledDone);
    led_drop    = lvDataValid && (led_state == LED_BUSY) && !ledDone;
  end

  assign busy = (nf_state != NF_IDLE) || (led_state != LED_IDLE);

  SatCounter #(.W(CNT_W)) u_nf_overruns (
    .clk   (clk),
    .rst   (rst),
    .inc   (nf_drop),
    .clr   (clearStats),
    .count (nfOverruns)
  );

  SatCounter #(.W(CNT_W)) u_led_drops (
    .clk   (clk),
    .rst   (rst),
    .inc   (led_drop),
    .clr   (clearStats),
    .count (ledDrops)
  );

endmodule
